// File: rtl/lagarto_fetch_pkg.sv
// lagarto_fetch_pkg: shared fetch-queue entry record and default sizing
package lagarto_fetch_pkg;
    localparam int FQ_DEPTH  = 4;
    localparam int FQ_ADDR_W = 40;
    localparam int PC_MAX_W  = 64;
    typedef struct packed {
        logic [PC_MAX_W-1:0] pc;
        logic [31:0]         inst;
        logic                xcpt_misaligned;
        logic                xcpt_if;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: fetch-to-decode instruction FIFO with flush and fault hold; FETCH_QUEUE_BYPASS_EN enables empty-queue bypass
module fetch_queue
    import lagarto_fetch_pkg::*;
#(
    parameter int DEPTH  = FQ_DEPTH,
    parameter int ADDR_W = FQ_ADDR_W
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     FLUSH,
    input  logic                     FETCH_VALID,
    input  logic [ADDR_W-1:0]        FETCH_PC,
    input  logic [31:0]              FETCH_INST,
    input  logic                     FETCH_XCPT_MISALIGNED,
    input  logic                     FETCH_XCPT_IF,
    output logic                     FETCH_READY,
    input  logic                     DEC_READY,
    output logic                     DEC_VALID,
    output logic [ADDR_W-1:0]        DEC_PC,
    output logic [31:0]              DEC_INST,
    output logic                     DEC_XCPT_MISALIGNED,
    output logic                     DEC_XCPT_IF,
    output logic [$clog2(DEPTH):0]   QUEUE_COUNT
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  in_e, head_e;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          hold_q, hold_d;
    logic          empty, full, push, pop, byp, store, mem_pop;

    // handshake, bypass selection and next-state computation
    always_comb begin
        in_e.pc              = PC_MAX_W'(FETCH_PC);
        in_e.inst            = FETCH_INST;
        in_e.xcpt_misaligned = FETCH_XCPT_MISALIGNED;
        in_e.xcpt_if         = FETCH_XCPT_IF;
        empty       = count_q == '0;
        full        = count_q == CW'(DEPTH);
        FETCH_READY = ~RST & ~full & ~hold_q;
        push        = FETCH_VALID & FETCH_READY & ~FLUSH;
`ifdef FETCH_QUEUE_BYPASS_EN
        byp    = push & empty;
        head_e = byp ? in_e : mem_q[rd_ptr_q];
`else
        byp    = 1'b0;
        head_e = mem_q[rd_ptr_q];
`endif
        DEC_VALID = ~RST & (~empty | byp);
        pop       = DEC_VALID & DEC_READY & ~FLUSH;
        store     = push & ~(byp & DEC_READY);
        mem_pop   = pop & ~byp;
        count_d   = FLUSH ? '0 : count_q + CW'(store) - CW'(mem_pop);
        wr_ptr_d  = FLUSH ? '0 : wr_ptr_q + PW'(store);
        rd_ptr_d  = FLUSH ? '0 : rd_ptr_q + PW'(mem_pop);
        hold_d    = FLUSH ? 1'b0 : hold_q | (push & (FETCH_XCPT_MISALIGNED | FETCH_XCPT_IF));
        DEC_PC              = DEC_VALID ? head_e.pc[ADDR_W-1:0] : '0;
        DEC_INST            = DEC_VALID ? head_e.inst : '0;
        DEC_XCPT_MISALIGNED = DEC_VALID & head_e.xcpt_misaligned;
        DEC_XCPT_IF         = DEC_VALID & head_e.xcpt_if;
        QUEUE_COUNT         = RST ? '0 : count_q;
    end

    // control state: occupancy, pointers and fault hold
    always_ff @(posedge CLK) begin
        if (RST) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            hold_q   <= 1'b0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            hold_q   <= hold_d;
        end
    end

    // entry storage, intentionally not reset
    always_ff @(posedge CLK) begin
        if (store) mem_q[wr_ptr_q] <= in_e;
    end
endmodule
